edge_stream_filter: RTL and testbench

Parametrised streaming 3x3 edge detector, successor to the team's fixed-size Sobel filter. Accepts one raster-order pixel per handshake, keeps two line buffers plus a 3x3 window shift register, and emits the (IMG_HEIGHT-2)x(IMG_WIDTH-2) interior gradient image through a back-pressured output stream. Sits between the camera/frame-read DMA and the frame-write path of the vision pipeline.

---
 rtl/edge_filter_pkg.sv | 34 +++
 rtl/edge_line_buffer.sv | 33 +++
 rtl/edge_stream_filter.sv | 200 ++++++++++++++++++++
 tb/tb_edge_stream_filter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_filter_pkg.sv
// Shared types and width helpers for the streaming 3x3 edge filter.
package edge_filter_pkg;

  typedef enum logic [1:0] {
    MODE_SOBEL   = 2'd0,
    MODE_PREWITT = 2'd1,
    MODE_SOBEL_X = 2'd2,
    MODE_SOBEL_Y = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sideband flags travelling down the pipeline with each pixel
  typedef struct packed {
    logic valid;
    logic last;
    logic final_px;
  } tag_t;

  // Signed gradient width: up to +/-4*(2^PIX_W-1)
  function automatic int unsigned grad_w(input int unsigned pix_w);
    return pix_w + 3;
  endfunction

  // Unsigned magnitude width: |Gx|+|Gy| up to 8*(2^PIX_W-1)
  function automatic int unsigned mag_w(input int unsigned pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// Two-row line buffer: presents the column (row-2, row-1, current) at in_col.
module edge_line_buffer
  import edge_filter_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned IMG_WIDTH = 640,
  localparam int unsigned COL_W    = $clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] col,
  input  logic [PIX_W-1:0] pixel,
  output logic [PIX_W-1:0] top_c,
  output logic [PIX_W-1:0] mid_c,
  output logic [PIX_W-1:0] bot_c
);

  logic [PIX_W-1:0] row_a [IMG_WIDTH];
  logic [PIX_W-1:0] row_b [IMG_WIDTH];

  // Shift the column down one row on every accepted pixel
  always_ff @(posedge clk) begin
    if (wr_en) begin
      row_a[col] <= pixel;
      row_b[col] <= row_a[col];
    end
  end

  assign top_c = row_b[col];
  assign mid_c = row_a[col];
  assign bot_c = pixel;

endmodule

// File: rtl/edge_stream_filter.sv
// Streaming 3x3 Sobel/Prewitt edge detector with back-pressured output.
// Optional binarisation output enabled by defining EDGE_THRESH_EN.
module edge_stream_filter
  import edge_filter_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_pixel,
  output logic             m_last,
  output logic             busy,
  output logic             done
`ifdef EDGE_THRESH_EN
  ,
  input  logic [PIX_W-1:0] thr
`endif
);

  localparam int unsigned GRAD_W = grad_w(PIX_W);
  localparam int unsigned MAG_W  = mag_w(PIX_W);
  localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);

  state_e state_q, state_d;
  mode_e  mode_q;

  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic             in_done;

  logic en, acc, start_acc, out_hs;
  logic m_final;
  tag_t tag_in_c, tag0, tag1;

  logic [PIX_W-1:0] lb_top_c, lb_mid_c, lb_bot_c;
  logic [PIX_W-1:0] win [3][3];  // [column][row], column 2 newest, row 0 top

  logic signed [GRAD_W-1:0] lsum_c, rsum_c, tsum_c, bsum_c, gx_c, gy_c;
  logic signed [GRAD_W-1:0] gx_q, gy_q;
  logic [GRAD_W-1:0] ax_c, ay_c;
  logic [MAG_W-1:0]  mag_c;
  logic [PIX_W-1:0]  sat_c, pix_c;

  assign en        = !m_valid || m_ready;
  assign s_ready   = (state_q == RUN) && en && !in_done;
  assign acc       = s_valid && s_ready;
  assign out_hs    = m_valid && m_ready;
  assign start_acc = (state_q == IDLE) && start;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (out_hs && m_final) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Input raster counters and per-frame mode capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col  <= '0;
      in_row  <= '0;
      in_done <= 1'b0;
      mode_q  <= MODE_SOBEL;
    end else if (start_acc) begin
      in_col  <= '0;
      in_row  <= '0;
      in_done <= 1'b0;
      mode_q  <= mode_e'(mode);
    end else if (acc) begin
      if (in_col == COL_W'(IMG_WIDTH - 1)) begin
        in_col <= '0;
        if (in_row == ROW_W'(IMG_HEIGHT - 1)) in_done <= 1'b1;
        else                                  in_row  <= in_row + ROW_W'(1);
      end else begin
        in_col <= in_col + COL_W'(1);
      end
    end
  end

  edge_line_buffer #(
    .PIX_W    (PIX_W),
    .IMG_WIDTH(IMG_WIDTH)
  ) u_line_buffer (
    .clk  (clk),
    .wr_en(acc),
    .col  (in_col),
    .pixel(s_pixel),
    .top_c(lb_top_c),
    .mid_c(lb_mid_c),
    .bot_c(lb_bot_c)
  );

  // 3x3 window shift; contents only matter when a valid tag follows them
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win[0][r] <= win[1][r];
        win[1][r] <= win[2][r];
      end
      win[2][0] <= lb_top_c;
      win[2][1] <= lb_mid_c;
      win[2][2] <= lb_bot_c;
    end
  end

  // Tag for the pixel being accepted: interior once two rows/cols seen
  always_comb begin
    tag_in_c          = '0;
    tag_in_c.valid    = acc && (in_row >= ROW_W'(2)) && (in_col >= COL_W'(2));
    tag_in_c.last     = (in_col == COL_W'(IMG_WIDTH - 1));
    tag_in_c.final_px = tag_in_c.last && (in_row == ROW_W'(IMG_HEIGHT - 1));
  end

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return GRAD_W'(p);
  endfunction

  function automatic logic signed [GRAD_W-1:0] mid_w(input logic [PIX_W-1:0] p,
                                                      input logic prewitt);
    return prewitt ? ext(p) : (ext(p) <<< 1);
  endfunction

  // Gradients from the window; Gx = right - left, Gy = top - bottom
  always_comb begin
    lsum_c = ext(win[0][0]) + mid_w(win[0][1], mode_q == MODE_PREWITT) + ext(win[0][2]);
    rsum_c = ext(win[2][0]) + mid_w(win[2][1], mode_q == MODE_PREWITT) + ext(win[2][2]);
    tsum_c = ext(win[0][0]) + mid_w(win[1][0], mode_q == MODE_PREWITT) + ext(win[2][0]);
    bsum_c = ext(win[0][2]) + mid_w(win[1][2], mode_q == MODE_PREWITT) + ext(win[2][2]);
    gx_c   = rsum_c - lsum_c;
    gy_c   = tsum_c - bsum_c;
  end

  // Magnitude, saturation and optional threshold
  always_comb begin
    ax_c = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay_c = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    case (mode_q)
      MODE_SOBEL_X: mag_c = MAG_W'(ax_c);
      MODE_SOBEL_Y: mag_c = MAG_W'(ay_c);
      default:      mag_c = MAG_W'(ax_c) + MAG_W'(ay_c);
    endcase
    sat_c = (|mag_c[MAG_W-1:PIX_W]) ? '1 : mag_c[PIX_W-1:0];
`ifdef EDGE_THRESH_EN
    pix_c = (sat_c >= thr) ? '1 : '0;
`else
    pix_c = sat_c;
`endif
  end

  // Two-stage pipeline: gradient, then magnitude into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag0    <= '0;
      tag1    <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      m_valid <= 1'b0;
      m_pixel <= '0;
      m_last  <= 1'b0;
      m_final <= 1'b0;
    end else if (en) begin
      tag0    <= tag_in_c;
      tag1    <= tag0;
      gx_q    <= gx_c;
      gy_q    <= gy_c;
      m_valid <= tag1.valid;
      m_last  <= tag1.valid && tag1.last;
      m_final <= tag1.valid && tag1.final_px;
      if (tag1.valid) m_pixel <= pix_c;
    end
  end

endmodule

// File: tb/tb_edge_stream_filter.sv
// Scoreboard bench for edge_stream_filter: 8-bit 5x5 and 10-bit 4x4 instances.
// Honours EDGE_THRESH_EN when defined.
module tb_edge_stream_filter;

  localparam int unsigned PW0 = 8;
  localparam int unsigned W0  = 5;
  localparam int unsigned H0  = 5;
  localparam int unsigned PW1 = 10;
  localparam int unsigned W1  = 4;
  localparam int unsigned H1  = 4;

  typedef struct packed {
    logic [15:0] pix;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start   [2];
  logic [1:0]  mode    [2];
  logic        s_valid [2];
  logic [15:0] sp      [2];
  logic        m_ready [2];
  logic [1:0]  s_ready_v, m_valid_v, m_last_v, busy_v, done_v;
  logic [PW0-1:0] mp0;
  logic [PW1-1:0] mp1;

  int n_cmp = 0;
  int n_bad = 0;
  int img [5][5];
  exp_t sb [2][$];
  int out_cnt [2];
  int done_cnt [2];
  bit rand_ready [2];
  bit held [2];
  int hold_pix [2];
  int hold_last [2];
  int unsigned cyc = 0;

  edge_stream_filter #(.PIX_W(PW0), .IMG_WIDTH(W0), .IMG_HEIGHT(H0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready_v[0]), .s_pixel(sp[0][PW0-1:0]),
    .m_valid(m_valid_v[0]), .m_ready(m_ready[0]), .m_pixel(mp0),
    .m_last(m_last_v[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef EDGE_THRESH_EN
    , .thr(8'd128)
`endif
  );

  edge_stream_filter #(.PIX_W(PW1), .IMG_WIDTH(W1), .IMG_HEIGHT(H1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready_v[1]), .s_pixel(sp[1][PW1-1:0]),
    .m_valid(m_valid_v[1]), .m_ready(m_ready[1]), .m_pixel(mp1),
    .m_last(m_last_v[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef EDGE_THRESH_EN
    , .thr(10'd512)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pw(input int d);  return (d == 0) ? PW0 : PW1; endfunction
  function automatic int wd(input int d);  return (d == 0) ? W0 : W1;   endfunction
  function automatic int ht(input int d);  return (d == 0) ? H0 : H1;   endfunction
  function automatic int thr_of(input int d); return (d == 0) ? 128 : 512; endfunction
  function automatic int get_pix(input int d);
    return (d == 0) ? int'(mp0) : int'(mp1);
  endfunction

  // Golden model: direct 3x3 convolution on the stored frame centred at (r, c)
  function automatic int model(input int d, input int md, input int r, input int c);
    int p [3][3];
    int wc, gx, gy, ax, ay, m, maxv;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-1+i][c-1+j];
    wc = (md == 1) ? 1 : 2;
    gx = (p[0][2] + wc*p[1][2] + p[2][2]) - (p[0][0] + wc*p[1][0] + p[2][0]);
    gy = (p[0][0] + wc*p[0][1] + p[0][2]) - (p[2][0] + wc*p[2][1] + p[2][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      2:       m = ax;
      3:       m = ay;
      default: m = ax + ay;
    endcase
    maxv = (1 << pw(d)) - 1;
    if (m > maxv) m = maxv;
`ifdef EDGE_THRESH_EN
    m = (m >= thr_of(d)) ? maxv : 0;
`endif
    return m;
  endfunction

  // Output monitor: pop and compare on each handshake, check hold while stalled
  task automatic monitor(input int d);
    exp_t e;
    if (!rst_n) begin
      held[d] = 1'b0;
      return;
    end
    if (held[d]) begin
      check($sformatf("d%0d_hold_valid", d), int'(m_valid_v[d]), 1);
      check($sformatf("d%0d_hold_pix", d), get_pix(d), hold_pix[d]);
      check($sformatf("d%0d_hold_last", d), int'(m_last_v[d]), hold_last[d]);
    end
    if (m_valid_v[d] && m_ready[d]) begin
      out_cnt[d]++;
      if (sb[d].size() == 0) begin
        check($sformatf("d%0d_extra_output", d), 1, 0);
      end else begin
        e = sb[d].pop_front();
        check($sformatf("d%0d_pix#%0d", d, out_cnt[d]), get_pix(d), int'(e.pix));
        check($sformatf("d%0d_last#%0d", d, out_cnt[d]), int'(m_last_v[d]), int'(e.last));
      end
    end
    if (done_v[d]) done_cnt[d]++;
    held[d]      = m_valid_v[d] && !m_ready[d];
    hold_pix[d]  = get_pix(d);
    hold_last[d] = int'(m_last_v[d]);
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always high unless randomised for this DUT
  initial forever begin
    for (int d = 0; d < 2; d++)
      m_ready[d] = rand_ready[d] ? 1'($urandom_range(1)) : 1'b1;
    @(posedge clk);
    #1;
  end

  task automatic fill(input int kind, input int a, input int b, input int d);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        case (kind)
          0:       img[r][c] = a;
          1:       img[r][c] = (c < 2) ? a : b;
          default: img[r][c] = int'($urandom_range((1 << pw(d)) - 1));
        endcase
  endtask

  task automatic check_reset(input int d);
    check($sformatf("d%0d_rst_s_ready", d), int'(s_ready_v[d]), 0);
    check($sformatf("d%0d_rst_m_valid", d), int'(m_valid_v[d]), 0);
    check($sformatf("d%0d_rst_m_pixel", d), get_pix(d), 0);
    check($sformatf("d%0d_rst_m_last", d), int'(m_last_v[d]), 0);
    check($sformatf("d%0d_rst_busy", d), int'(busy_v[d]), 0);
    check($sformatf("d%0d_rst_done", d), int'(done_v[d]), 0);
  endtask

  // One full frame: push expectations, start, stream pixels, wait for done
  task automatic run_frame(input int d, input int md, input bit gaps, input bit glitch);
    exp_t e;
    int exp_n, cnt;
    bit hs;
    int unsigned last_cyc;
    for (int r = 1; r <= ht(d) - 2; r++)
      for (int c = 1; c <= wd(d) - 2; c++) begin
        e.pix  = 16'(model(d, md, r, c));
        e.last = (c == wd(d) - 2);
        sb[d].push_back(e);
      end
    exp_n       = (ht(d) - 2) * (wd(d) - 2);
    out_cnt[d]  = 0;
    done_cnt[d] = 0;
    last_cyc    = 0;
    mode[d]  = 2'(md);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    mode[d]  = 2'(md + 1);
    @(negedge clk);
    check($sformatf("d%0d_busy_run", d), int'(busy_v[d]), 1);
    @(posedge clk); #1;
    for (int i = 0; i < ht(d) * wd(d); i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        s_valid[d] = 1'b0;
        @(posedge clk); #1;
      end
      sp[d]      = 16'(img[i / wd(d)][i % wd(d)]);
      s_valid[d] = 1'b1;
      cnt = 0;
      do begin
        @(negedge clk);
        hs       = s_valid[d] && s_ready_v[d];
        last_cyc = cyc;
        @(posedge clk); #1;
        cnt++;
      end while (!hs && cnt < 500);
      start[d] = (glitch && i == 7) ? 1'b1 : 1'b0;
      if (!hs) begin
        check($sformatf("d%0d_s_ready_timeout", d), 0, 1);
        break;
      end
    end
    s_valid[d] = 1'b0;
    start[d]   = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done_v[d] && cnt < 2000);
    if (!done_v[d]) check($sformatf("d%0d_done_timeout", d), 0, 1);
    else if (!rand_ready[d]) check($sformatf("d%0d_done_latency", d), int'(cyc - last_cyc), 4);
    repeat (4) @(negedge clk);
    check($sformatf("d%0d_out_count", d), out_cnt[d], exp_n);
    check($sformatf("d%0d_done_pulses", d), done_cnt[d], 1);
    check($sformatf("d%0d_sb_empty", d), sb[d].size(), 0);
    check($sformatf("d%0d_busy_after", d), int'(busy_v[d]), 0);
    check($sformatf("d%0d_s_ready_idle", d), int'(s_ready_v[d]), 0);
    sb[d].delete();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; mode[d] = 2'd0; s_valid[d] = 1'b0; sp[d] = 16'd0;
      rand_ready[d] = 1'b0; out_cnt[d] = 0; done_cnt[d] = 0; held[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Flat image, Sobel: all zero, last on every third output
    fill(0, 100, 0, 0);
    run_frame(0, 0, 1'b0, 1'b0);
    // Vertical step 0/200: Sobel saturates where the step sits in the window
    fill(1, 0, 200, 0);
    run_frame(0, 0, 1'b0, 1'b0);
    // Same step, vertical gradient only: zero
    run_frame(0, 3, 1'b0, 1'b0);
    // Small steps around the threshold, horizontal gradient only
    fill(1, 0, 20, 0);
    run_frame(0, 2, 1'b0, 1'b0);
    fill(1, 0, 40, 0);
    run_frame(0, 2, 1'b0, 1'b0);

    // Reset mid-frame on the 10-bit 4x4 instance, then a clean Prewitt frame
    fill(2, 0, 0, 1);
    start[1] = 1'b1; mode[1] = 2'd0;
    @(posedge clk); #1;
    start[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sp[1] = 16'(img[i / 4][i % 4]);
      s_valid[1] = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    s_valid[1] = 1'b0;
    @(negedge clk);
    check_reset(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill(1, 0, 200, 1);
    run_frame(1, 1, 1'b0, 1'b0);

    // Random images with random back-pressure, input gaps and ignored start
    rand_ready[0] = 1'b1;
    rand_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fill(2, 0, 0, 0);
      run_frame(0, int'($urandom_range(3)), 1'b1, 1'b1);
      fill(2, 0, 0, 1);
      run_frame(1, int'($urandom_range(3)), 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
